// File: rtl/alu_control_pkg.sv
// alu_control_pkg: ALU operation codes, instruction field encodings and MDU FSM states.
package alu_control_pkg;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_SLL  = 5'd4;
    localparam logic [4:0] ALU_SRL  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_XOR  = 5'd7;
    localparam logic [4:0] ALU_SLLV = 5'd8;
    localparam logic [4:0] ALU_SRLV = 5'd9;
    localparam logic [4:0] ALU_SLT  = 5'd10;
    localparam logic [4:0] ALU_NOR  = 5'd13;
    localparam logic [4:0] ALU_MOVN = 5'd16;
    localparam logic [4:0] ALU_MOVZ = 5'd17;
    localparam logic [4:0] ALU_SRA  = 5'd19;
    localparam logic [4:0] ALU_SRAV = 5'd20;
    localparam logic [4:0] ALU_SLTU = 5'd22;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_MOVZ = 6'b001010;
    localparam logic [5:0] F_MOVN = 6'b001011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    typedef enum logic {MDU_IDLE, MDU_RUN} mdu_state_t;
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide on operand magnitudes, one bit per cycle,
// with sign fix-up on the final iteration and HI/LO register ownership.
module mdu_iter import alu_control_pkg::*; #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] rs,
    input  logic [W-1:0] rt,
    input  logic         wr_hi,
    input  logic         wr_lo,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = $clog2(W);
    mdu_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2*W-1:0] p, p_nx, prod;
    logic [W-1:0] m, ars, art, dif, q_res, r_res;
    logic [W:0] sum;
    logic is_div, neg, neg_rem, rs_neg, rt_neg, qb, last;
    assign busy = state == MDU_RUN;
    assign last = cnt == CW'(W - 1);
    assign rs_neg = !op[0] && rs[W-1];
    assign rt_neg = !op[0] && rt[W-1];
    assign ars = rs_neg ? -rs : rs;
    assign art = rt_neg ? -rt : rt;
    // p holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign sum = {1'b0, p[2*W-1:W]} + {1'b0, {W{p[0]}} & m};
    assign qb = p[2*W-1:W-1] >= {1'b0, m};
    assign dif = p[2*W-2:W-1] - m;
    assign p_nx = is_div ? {qb ? dif : p[2*W-2:W-1], p[W-2:0], qb} : {sum, p[W-1:1]};
    assign prod = neg ? -p_nx : p_nx;
    assign q_res = p_nx[W-1:0];
    assign r_res = p_nx[2*W-1:W];
    always_comb begin
        state_nx = state;
        if (state == MDU_IDLE && start) state_nx = MDU_RUN;
        else if (state == MDU_RUN && last) state_nx = MDU_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= MDU_IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            p <= '0;
            m <= '0;
            is_div <= 1'b0;
            neg <= 1'b0;
            neg_rem <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else if (busy) begin
            cnt <= cnt + CW'(1);
            p <= p_nx;
            if (last) begin
                // a zero divisor leaves |dividend| as remainder, so the sign fix restores RsData
                hi <= is_div ? (neg_rem ? -r_res : r_res) : prod[2*W-1:W];
                lo <= !is_div ? prod[W-1:0] : m == '0 ? '1 : neg ? -q_res : q_res;
            end
        end else if (start) begin
            cnt <= '0;
            p <= {{W{1'b0}}, op[1] ? ars : art};
            m <= op[1] ? art : ars;
            is_div <= op[1];
            neg <= rs_neg ^ rt_neg;
            neg_rem <= rs_neg;
        end else begin
            if (wr_hi) hi <= rs;
            if (wr_lo) lo <= rs;
        end
    end
endmodule

// File: rtl/alu_control_mdu.sv
// alu_control_mdu: EX-stage ALU operation decoder with an attached iterative MDU;
// stalls the pipeline when an MDU instruction meets a busy MDU.
module alu_control_mdu import alu_control_pkg::*; #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALUCTL_WIDTH = 5
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Valid,
    input  logic [1:0]              ALUOp,
    input  logic [5:0]              Opcode,
    input  logic [5:0]              Funct,
    input  logic [DATA_WIDTH-1:0]   RsData,
    input  logic [DATA_WIDTH-1:0]   RtData,
    output logic [ALUCTL_WIDTH-1:0] ALUControl,
    output logic [DATA_WIDTH-1:0]   Hi,
    output logic [DATA_WIDTH-1:0]   Lo,
    output logic                    Busy,
    output logic                    Stall
);
    logic [4:0] code;
    logic rtype, mdu_ar, mdu_mv, start, issue_mv;
    assign rtype = ALUOp == 2'b10;
    assign mdu_ar = rtype && Funct[5:2] == F_MULT[5:2];
    assign mdu_mv = rtype && Funct[5:2] == F_MFHI[5:2];
    assign start = Valid && mdu_ar && !Busy;
    assign issue_mv = Valid && mdu_mv && !Busy;
    assign Stall = Valid && Busy && (mdu_ar || mdu_mv);
    assign ALUControl = ALUCTL_WIDTH'(code);
    always_comb begin
        code = ALU_ADD;
        case (ALUOp)
            2'b01: code = ALU_SUB;
            2'b11:
                case (Opcode)
                    OP_ANDI:  code = ALU_AND;
                    OP_ORI:   code = ALU_OR;
                    OP_XORI:  code = ALU_XOR;
                    OP_SLTI:  code = ALU_SLT;
                    OP_SLTIU: code = ALU_SLTU;
                    default:  code = ALU_ADD;
                endcase
            2'b10:
                case (Funct)
                    F_SUB:   code = ALU_SUB;
                    F_AND:   code = ALU_AND;
                    F_OR:    code = ALU_OR;
                    F_NOR:   code = ALU_NOR;
                    F_XOR:   code = ALU_XOR;
                    F_SLT:   code = ALU_SLT;
                    F_SLTU:  code = ALU_SLTU;
                    F_SLL:   code = ALU_SLL;
                    F_SRL:   code = ALU_SRL;
                    F_SRA:   code = ALU_SRA;
                    F_SLLV:  code = ALU_SLLV;
                    F_SRLV:  code = ALU_SRLV;
                    F_SRAV:  code = ALU_SRAV;
                    F_MOVN:  code = ALU_MOVN;
                    F_MOVZ:  code = ALU_MOVZ;
                    default: code = ALU_ADD;
                endcase
            default: code = ALU_ADD;
        endcase
    end
    mdu_iter #(.W(DATA_WIDTH)) u_mdu (
        .clk(Clk),
        .rst(Reset),
        .start(start),
        .op(Funct[1:0]),
        .rs(RsData),
        .rt(RtData),
        .wr_hi(issue_mv && Funct == F_MTHI),
        .wr_lo(issue_mv && Funct == F_MTLO),
        .busy(Busy),
        .hi(Hi),
        .lo(Lo)
    );
endmodule

// File: tb/tb_alu_control_mdu.sv
// tb_alu_control_mdu: random and directed checks of the decoder, MDU results/timing,
// stall behaviour, mthi/mtlo and mid-operation reset against a behavioural model.
module tb_alu_control_mdu;
    logic Clk = 0, Reset = 1, Valid = 0;
    logic [1:0] ALUOp = 0;
    logic [5:0] Opcode = 0, Funct = 0;
    logic [31:0] RsData = 0, RtData = 0;
    logic [4:0] ALUControl;
    logic [31:0] Hi, Lo;
    logic Busy, Stall;
    int n_chk = 0, n_pass = 0;
    logic [5:0] fkey[16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2A, 6'h2B,
                             6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0B, 6'h0A};
    int fcode[16] = '{0, 1, 3, 6, 13, 7, 10, 22, 4, 5, 19, 8, 9, 20, 16, 17};
    logic [5:0] okey[6] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B};
    int ocode[6] = '{0, 3, 6, 7, 10, 22};
    logic [5:0] mkey[8] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13};

    alu_control_mdu dut (
        .Clk(Clk), .Reset(Reset), .Valid(Valid), .ALUOp(ALUOp), .Opcode(Opcode),
        .Funct(Funct), .RsData(RsData), .RtData(RtData), .ALUControl(ALUControl),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Stall(Stall)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int dec(input logic [1:0] op, input logic [5:0] oc, input logic [5:0] fn);
        int r = 0;
        if (op == 2'b01) r = 1;
        else if (op == 2'b11) begin
            foreach (okey[i]) if (okey[i] == oc) r = ocode[i];
        end else if (op == 2'b10) begin
            foreach (fkey[i]) if (fkey[i] == fn) r = fcode[i];
        end
        return r;
    endfunction

    function automatic logic [63:0] mdu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (f == 6'h18) r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        else if (f == 6'h19) r = {32'h0, a} * {32'h0, b};
        else if (b == 0) r = {a, 32'hFFFFFFFF};
        else if (f == 6'h1A && a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else if (f == 6'h1A) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        else r = {a % b, a / b};
        return r;
    endfunction

    task automatic run_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
        int n = 0;
        @(negedge Clk);
        Valid = 1; ALUOp = 2'b10; Funct = f; RsData = a; RtData = b;
        #1;
        check("mdu_stall_idle", 32'(Stall), 32'd0);
        check("mdu_aluctl", 32'(ALUControl), 32'd0);
        @(negedge Clk);
        Valid = 0;
        while (Busy && n < 100) begin
            n++;
            @(negedge Clk);
        end
        check("mdu_busy_cycles", 32'(n), 32'd32);
        check("mdu_hi", Hi, e[63:32]);
        check("mdu_lo", Lo, e[31:0]);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_hi", Hi, 32'd0);
        check("rst_lo", Lo, 32'd0);
        Reset = 0;
        // directed decode cases
        ALUOp = 2'b10; Funct = 6'b100111; #1; check("dec_nor", 32'(ALUControl), 32'd13);
        Funct = 6'b101011; #1; check("dec_sltu", 32'(ALUControl), 32'd22);
        Funct = 6'b111111; #1; check("dec_unknown", 32'(ALUControl), 32'd0);
        ALUOp = 2'b11; Opcode = 6'b001100; #1; check("dec_andi", 32'(ALUControl), 32'd3);
        ALUOp = 2'b01; #1; check("dec_sub", 32'(ALUControl), 32'd1);
        // random decode sweep with Valid low: nothing may start or be written
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            ALUOp = 2'($urandom_range(0, 3));
            Opcode = $urandom_range(0, 1) ? okey[$urandom_range(0, 5)] : 6'($urandom);
            case ($urandom_range(0, 2))
                0: Funct = fkey[$urandom_range(0, 15)];
                1: Funct = mkey[$urandom_range(0, 7)];
                default: Funct = 6'($urandom);
            endcase
            RsData = $urandom; RtData = $urandom;
            #1;
            check("dec_rand", 32'(ALUControl), 32'(dec(ALUOp, Opcode, Funct)));
        end
        @(negedge Clk);
        check("novalid_busy", 32'(Busy), 32'd0);
        check("novalid_hi", Hi, 32'd0);
        check("novalid_lo", Lo, 32'd0);
        // directed MDU operations
        run_mdu(6'h18, 32'd7, 32'hFFFFFFFD, {32'hFFFFFFFF, 32'hFFFFFFEB});
        run_mdu(6'h19, 32'd7, 32'hFFFFFFFD, {32'h00000006, 32'hFFFFFFEB});
        run_mdu(6'h1B, 32'd100, 32'd7, {32'd2, 32'd14});
        run_mdu(6'h1A, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_mdu(6'h1A, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
        run_mdu(6'h1A, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF});
        run_mdu(6'h1A, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
        // random MDU operations
        for (int i = 0; i < 16; i++) begin
            logic [5:0] f;
            logic [31:0] a, b;
            f = mkey[$urandom_range(0, 3)];
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_mdu(f, a, b, mdu_ref(f, a, b));
        end
        // mflo three cycles after mult stalls until Busy falls; add never stalls
        @(negedge Clk);
        Valid = 1; ALUOp = 2'b10; Funct = 6'h18; RsData = 32'd7; RtData = 32'hFFFFFFFD;
        @(negedge Clk);
        Valid = 0;
        @(negedge Clk);
        @(negedge Clk);
        Valid = 1; Funct = 6'h12;
        for (int k = 3; k <= 33; k++) begin
            if (k == 20) begin
                Funct = 6'h20; #1;
                check("stall_add", 32'(Stall), 32'd0);
                Funct = 6'h12;
            end
            #1;
            check("stall_mflo", 32'(Stall), 32'(k <= 32));
            if (k == 33) check("mflo_lo", Lo, 32'hFFFFFFEB);
            if (k < 33) @(negedge Clk);
        end
        Valid = 0;
        // mthi while idle, then mthi held stalled behind a multu
        @(negedge Clk);
        Valid = 1; Funct = 6'h11; RsData = 32'h1234;
        @(negedge Clk);
        Valid = 0;
        check("mthi_idle", Hi, 32'h1234);
        @(negedge Clk);
        Valid = 1; Funct = 6'h19; RsData = 32'd3; RtData = 32'd5;
        @(negedge Clk);
        Valid = 0;
        @(negedge Clk);
        Valid = 1; Funct = 6'h11; RsData = 32'hABCD;
        for (int k = 2; k <= 33; k++) begin
            #1;
            check("mthi_stall", 32'(Stall), 32'(k <= 32));
            check("mthi_hold", Hi, k <= 32 ? 32'h1234 : 32'h0);
            if (k < 33) @(negedge Clk);
        end
        check("mthi_mul_lo", Lo, 32'd15);
        @(negedge Clk);
        Valid = 0;
        check("mthi_after", Hi, 32'hABCD);
        check("mthi_lo_kept", Lo, 32'd15);
        // reset in the middle of a divide
        @(negedge Clk);
        Valid = 1; Funct = 6'h1A; RsData = 32'd100; RtData = 32'd7;
        @(negedge Clk);
        Valid = 0;
        repeat (9) @(negedge Clk);
        check("pre_rst_busy", 32'(Busy), 32'd1);
        Reset = 1;
        @(negedge Clk);
        Reset = 0;
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_hi", Hi, 32'd0);
        check("midrst_lo", Lo, 32'd0);
        run_mdu(6'h18, 32'd12345, 32'hFFFFFD5A, mdu_ref(6'h18, 32'd12345, 32'hFFFFFD5A));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
